// File: rtl/shift_sequencer.sv
// shift_sequencer: holds a word and shifts/rotates it by an amount stepped manually or by a prescaled wrap/ping-pong sweep (in: clk, rst_n, data_in, data_we, cfg_we, cfg_auto, cfg_pingpong, cfg_rotate, cfg_left, cfg_amt, step; out: data_out, amount, dir_down, step_tick)
module shift_sequencer #(
  parameter int WIDTH    = 16,
  parameter int AMT_W    = $clog2(WIDTH),
  parameter int PRESCALE = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_we,
  input  logic             cfg_we,
  input  logic             cfg_auto,
  input  logic             cfg_pingpong,
  input  logic             cfg_rotate,
  input  logic             cfg_left,
  input  logic [AMT_W-1:0] cfg_amt,
  input  logic             step,
  output logic [WIDTH-1:0] data_out,
  output logic [AMT_W-1:0] amount,
  output logic             dir_down,
  output logic             step_tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [WIDTH-1:0] data_r;
  logic             auto_r;
  logic             pp_r;
  logic             rot_r;
  logic             left_r;
  logic [PW-1:0]    presc;
  logic             adv;
  logic [AMT_W-1:0] nxt_amt;
  logic             nxt_dir;
  logic [AMT_W-1:0] neg;
  logic [WIDTH-1:0] shifted;
  always_comb begin
    adv     = auto_r ? presc == PW'(PRESCALE - 1) : step;
    nxt_amt = !pp_r ? amount + AMT_W'(1) :
              dir_down ? (amount == '0 ? AMT_W'(1) : amount - AMT_W'(1)) :
              (&amount ? AMT_W'(WIDTH - 2) : amount + AMT_W'(1));
    nxt_dir = pp_r && (dir_down ? amount != '0 : &amount);
    neg     = -amount;
    shifted = cfg_left_sel(left_r) ? ((data_r << amount) | (rot_r ? data_r >> neg : '0)) :
              ((data_r >> amount) | (rot_r ? data_r << neg : '0));
  end
  function automatic logic cfg_left_sel(input logic l);
    return l;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r    <= '0;
      auto_r    <= 1'b0;
      pp_r      <= 1'b0;
      rot_r     <= 1'b0;
      left_r    <= 1'b0;
      amount    <= '0;
      presc     <= '0;
      dir_down  <= 1'b0;
      step_tick <= 1'b0;
      data_out  <= '0;
    end else begin
      if (data_we) data_r <= data_in;
      data_out <= shifted;
      if (cfg_we) begin
        auto_r    <= cfg_auto;
        pp_r      <= cfg_pingpong;
        rot_r     <= cfg_rotate;
        left_r    <= cfg_left;
        amount    <= cfg_amt;
        dir_down  <= 1'b0;
        presc     <= '0;
        step_tick <= 1'b0;
      end else begin
        presc     <= (auto_r && !adv) ? presc + PW'(1) : '0;
        step_tick <= adv;
        if (adv) begin
          amount   <= nxt_amt;
          dir_down <= nxt_dir;
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and random stimulus against a step-count reference model of shift_sequencer
module tb_shift_sequencer;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int P  = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          data_we = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_auto = 1'b0;
  logic          cfg_pingpong = 1'b0;
  logic          cfg_rotate = 1'b0;
  logic          cfg_left = 1'b0;
  logic [AW-1:0] cfg_amt = '0;
  logic          step = 1'b0;
  logic [W-1:0]  data_out;
  logic [AW-1:0] amount;
  logic          dir_down;
  logic          step_tick;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_data;
  bit m_auto, m_pp, m_rot, m_left, e_tick;
  int m_start, m_steps, m_cyc;
  logic [W-1:0] e_out;
  always #5 clk = ~clk;
  shift_sequencer #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_we(data_we), .cfg_we(cfg_we),
    .cfg_auto(cfg_auto), .cfg_pingpong(cfg_pingpong), .cfg_rotate(cfg_rotate),
    .cfg_left(cfg_left), .cfg_amt(cfg_amt), .step(step), .data_out(data_out),
    .amount(amount), .dir_down(dir_down), .step_tick(step_tick)
  );
  function automatic int m_amt();
    int p;
    if (!m_pp) return (m_start + m_steps) % W;
    p = (m_start + m_steps) % (2 * W - 2);
    return p < W ? p : 2 * W - 2 - p;
  endfunction
  function automatic bit m_dir();
    int p;
    if (!m_pp || m_steps == 0) return 1'b0;
    p = (m_start + m_steps) % (2 * W - 2);
    return p == 0 || p >= W;
  endfunction
  function automatic logic [W-1:0] shape(input logic [W-1:0] d, input bit rot, input bit left, input int a);
    logic [W-1:0] r;
    int src;
    for (int i = 0; i < W; i++) begin
      src = left ? i - a : i + a;
      if (src >= 0 && src < W) r[i] = d[src];
      else r[i] = rot ? d[(src + W) % W] : 1'b0;
    end
    return r;
  endfunction
  task automatic m_reset();
    m_data = '0; m_auto = 0; m_pp = 0; m_rot = 0; m_left = 0;
    m_start = 0; m_steps = 0; m_cyc = 0; e_out = '0; e_tick = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [W-1:0] nxt;
    bit a;
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      nxt = shape(m_data, m_rot, m_left, m_amt());
      if (cfg_we) begin
        m_auto = cfg_auto; m_pp = cfg_pingpong; m_rot = cfg_rotate; m_left = cfg_left;
        m_start = int'(cfg_amt); m_steps = 0; m_cyc = 0; e_tick = 0;
      end else begin
        if (m_auto) m_cyc++;
        a = m_auto ? (m_cyc % P == 0) : step;
        if (a) m_steps++;
        e_tick = a;
      end
      if (data_we) m_data = data_in;
      e_out = nxt;
    end
    #1;
    chk("data_out", 32'(data_out), 32'(e_out));
    chk("amount", 32'(amount), 32'(m_amt()));
    chk("dir_down", 32'(dir_down), 32'(m_dir()));
    chk("step_tick", 32'(step_tick), 32'(e_tick));
  endtask
  task automatic cfg(input bit au, input bit pp, input bit ro, input bit le, input int amt);
    cfg_auto = au; cfg_pingpong = pp; cfg_rotate = ro; cfg_left = le; cfg_amt = AW'(amt);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask
  initial begin
    m_reset();
    repeat (4) begin
      data_in = W'($urandom); data_we = 1'($urandom); cfg_we = 1'($urandom);
      cfg_auto = 1'($urandom); cfg_amt = AW'($urandom); step = 1'($urandom);
      tick();
    end
    chk("reset_out", 32'(data_out), 32'h0);
    chk("reset_amt", 32'(amount), 32'h0);
    data_we = 0; cfg_we = 0; cfg_auto = 0; cfg_amt = '0; step = 0;
    rst_n = 1'b1;
    tick();
    data_in = 16'h8001; data_we = 1'b1;
    tick();
    data_we = 1'b0;
    tick();
    chk("load_8001", 32'(data_out), 32'h8001);
    cfg(0, 0, 1, 1, 1);
    tick();
    chk("rotl1", 32'(data_out), 32'h0003);
    repeat (3) begin
      step = 1'b1; tick(); step = 1'b0; tick();
    end
    chk("rotl4", 32'(data_out), 32'h0018);
    cfg(0, 0, 0, 0, 15);
    tick();
    chk("shr15", 32'(data_out), 32'h0001);
    step = 1'b1; repeat (3) tick(); step = 1'b0;
    chk("step_level", 32'(amount), 32'd2);
    cfg(1, 0, 0, 0, 14);
    repeat (4) tick();
    chk("wrap_15", 32'(amount), 32'd15);
    repeat (4) tick();
    chk("wrap_0", 32'(amount), 32'd0);
    cfg(1, 1, 0, 0, 14);
    repeat (4) tick();
    chk("pp_15", 32'(amount), 32'd15);
    chk("pp_15_dir", 32'(dir_down), 32'd0);
    repeat (4) tick();
    chk("pp_14", 32'(amount), 32'd14);
    chk("pp_14_dir", 32'(dir_down), 32'd1);
    repeat (4) tick();
    chk("pp_13", 32'(amount), 32'd13);
    cfg(1, 1, 1, 0, 1);
    repeat (116) tick();
    chk("pp_0", 32'(amount), 32'd0);
    repeat (4) tick();
    chk("pp_back1", 32'(amount), 32'd1);
    chk("pp_back1_dir", 32'(dir_down), 32'd0);
    repeat (4) tick();
    chk("pp_back2", 32'(amount), 32'd2);
    cfg(1, 0, 0, 0, 0);
    repeat (3) tick();
    cfg(1, 0, 0, 0, 5);
    chk("coll_amt", 32'(amount), 32'd5);
    chk("coll_tick", 32'(step_tick), 32'd0);
    data_in = 16'h1234; data_we = 1'b1;
    cfg(0, 0, 1, 0, 3);
    data_we = 1'b0;
    tick();
    chk("both_we", 32'(data_out), 32'h8246);
    cfg(1, 1, 0, 1, 7);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1 m_reset();
    chk("arst_out", 32'(data_out), 32'h0);
    chk("arst_amt", 32'(amount), 32'h0);
    chk("arst_dir", 32'(dir_down), 32'h0);
    chk("arst_tick", 32'(step_tick), 32'h0);
    #2 rst_n = 1'b1;
    repeat (10) tick();
    chk("arst_hold", 32'(amount), 32'h0);
    repeat (400) begin
      data_in = W'($urandom); data_we = $urandom_range(0, 3) == 0;
      cfg_we = $urandom_range(0, 19) == 0;
      cfg_auto = 1'($urandom); cfg_pingpong = 1'($urandom); cfg_rotate = 1'($urandom);
      cfg_left = 1'($urandom); cfg_amt = AW'($urandom); step = 1'($urandom);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
